// File: rtl/gen3_rx_pkg.sv
// Purpose: shared constants and block-state type for the Gen3 receive descrambler.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package gen3_rx_pkg;

    // Scrambler LFSR width and the Galois tap mask for
    // x^23+x^21+x^16+x^8+x^5+x^2+1 (one bit per term below x^23).
    localparam int                LFSR_W    = 23;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 23'h210125;

    // 128b/130b sync headers.
    localparam logic [1:0] SYNC_DATA = 2'b10;
    localparam logic [1:0] SYNC_OS   = 2'b01;

    // First-symbol codes that identify ordered-set types.
    localparam logic [7:0] SKP_SYM     = 8'hAA;
    localparam logic [7:0] EIEOS_SYM   = 8'h00;
    localparam logic [7:0] SKP_END_SYM = 8'hE1;

    // Non-SKP blocks are 4 words of 32 bits; this is the index of the last one.
    localparam logic [2:0] STD_BLK_LAST  = 3'd3;
    localparam int         STD_BLK_WORDS = 4;

    typedef enum logic [2:0] {
        BLK_IDLE,
        BLK_DATA,
        BLK_OS,
        BLK_EIEOS,
        BLK_SKP,
        BLK_BAD
    } blk_state_t;

endpackage

// File: rtl/gen3_lfsr32_step.sv
// Purpose: advance the Gen3 scrambler LFSR by 32 serial bits, producing the keystream word.
// Latency: purely combinational.
// Backpressure: none.
// Ports: lfsr_in (current state) -> ks[31:0] (ks[0] is the first serial bit),
//        next_lfsr (state after 32 shifts).
module gen3_lfsr32_step
    import gen3_rx_pkg::*;
(
    input  logic [LFSR_W-1:0] lfsr_in,
    output logic [31:0]       ks,
    output logic [LFSR_W-1:0] next_lfsr
);

    logic [LFSR_W-1:0] l;

    // Serial Galois form unrolled 32 times: the keystream bit is the MSB,
    // which is then fed back into every tap position on the left shift.
    always_comb begin
        l  = lfsr_in;
        ks = '0;
        for (int i = 0; i < 32; i++) begin
            ks[i] = l[LFSR_W-1];
            l     = {l[LFSR_W-2:0], 1'b0} ^ (l[LFSR_W-1] ? LFSR_TAPS : '0);
        end
        next_lfsr = l;
    end

endmodule

// File: rtl/gen3_rx_descrambler.sv
// Purpose: 128b/130b receive descrambler for one lane; strips keystream from data blocks,
//          passes ordered sets raw, tracks the far-end LFSR (EIEOS re-seed, SKP hold).
// Latency: 1 pclk; Backpressure: none (in_valid=0 simply holds all state).
// Ports: pclk/reset_n; seed_value, lfsr_reset from LTSSM; in_valid/in_block_start/
//        in_sync_hdr/in_data from block alignment; out_* registered word stream with
//        out_is_data and one-cycle sync_hdr_err / blk_len_err pulses.
module gen3_rx_descrambler
    import gen3_rx_pkg::*;
#(
    parameter int SEED_W        = 24,
    parameter int SKP_MIN_WORDS = 2,
    parameter int SKP_MAX_WORDS = 6
) (
    input  logic              pclk,
    input  logic              reset_n,
    input  logic [SEED_W-1:0] seed_value,
    input  logic              lfsr_reset,
    input  logic              in_valid,
    input  logic              in_block_start,
    input  logic [1:0]        in_sync_hdr,
    input  logic [31:0]       in_data,
    output logic              out_valid,
    output logic [31:0]       out_data,
    output logic              out_block_start,
    output logic [1:0]        out_sync_hdr,
    output logic              out_is_data,
    output logic              sync_hdr_err,
    output logic              blk_len_err
);

    blk_state_t        state_q, state_d, blk_cls;
    logic [2:0]        word_cnt_q, word_cnt_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d, lfsr_adv, seed;
    logic [31:0]       ks, data_d;
    logic              is_data_d, hdr_err_d, len_err_d, prev_len_bad;
    int                prev_len;
    logic              unused_seed;

    assign seed        = seed_value[LFSR_W-1:0];
    assign unused_seed = ^seed_value[SEED_W-1:LFSR_W];

    gen3_lfsr32_step u_step (
        .lfsr_in   (lfsr_q),
        .ks        (ks),
        .next_lfsr (lfsr_adv)
    );

    // Block type from the sync header and the first symbol of the block.
    always_comb begin
        blk_cls = BLK_BAD;
        if (in_sync_hdr == SYNC_DATA) begin
            blk_cls = BLK_DATA;
        end else if (in_sync_hdr == SYNC_OS) begin
            if (in_data[7:0] == SKP_SYM)
                blk_cls = BLK_SKP;
            else if (in_data[7:0] == EIEOS_SYM)
                blk_cls = BLK_EIEOS;
            else
                blk_cls = BLK_OS;
        end
    end

    // word_cnt_q is the index of the last word taken, so the finished block
    // was word_cnt_q+1 words long when the next block start arrives.
    always_comb begin
        prev_len = int'(word_cnt_q) + 1;
        if (state_q == BLK_IDLE)
            prev_len_bad = 1'b0;
        else if (state_q == BLK_SKP)
            prev_len_bad = (prev_len < SKP_MIN_WORDS) || (prev_len > SKP_MAX_WORDS);
        else
            prev_len_bad = (prev_len != STD_BLK_WORDS);
    end

    // Next state, word index, LFSR and the word to present on the output.
    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        lfsr_d     = lfsr_q;
        data_d     = in_data;
        is_data_d  = 1'b0;
        hdr_err_d  = 1'b0;
        len_err_d  = 1'b0;
        if (in_valid) begin
            if (in_block_start) begin
                state_d    = blk_cls;
                word_cnt_d = 3'd0;
                hdr_err_d  = (blk_cls == BLK_BAD);
                len_err_d  = prev_len_bad;
            end else if (state_q != BLK_IDLE && word_cnt_q != 3'd7) begin
                word_cnt_d = word_cnt_q + 3'd1;
            end
            // Words past the 4th of a fixed-length block are overrun: raw, no advance.
            case (state_d)
                BLK_DATA: begin
                    is_data_d = 1'b1;
                    if (word_cnt_d <= STD_BLK_LAST) begin
                        data_d = in_data ^ ks;
                        lfsr_d = lfsr_adv;
                    end else begin
                        len_err_d = 1'b1;
                    end
                end
                BLK_OS, BLK_BAD: begin
                    if (word_cnt_d <= STD_BLK_LAST)
                        lfsr_d = lfsr_adv;
                    else
                        len_err_d = 1'b1;
                end
                BLK_EIEOS: begin
                    // The far end re-seeds once the whole EIEOS has gone out.
                    if (word_cnt_d < STD_BLK_LAST)
                        lfsr_d = lfsr_adv;
                    else if (word_cnt_d == STD_BLK_LAST)
                        lfsr_d = seed;
                    else
                        len_err_d = 1'b1;
                end
                default: ; // SKP and IDLE words leave the LFSR untouched
            endcase
        end
        if (lfsr_reset)
            lfsr_d = seed;
    end

    always_ff @(posedge pclk) begin
        if (!reset_n) begin
            state_q         <= BLK_IDLE;
            word_cnt_q      <= 3'd0;
            lfsr_q          <= seed;
            out_valid       <= 1'b0;
            out_data        <= '0;
            out_block_start <= 1'b0;
            out_sync_hdr    <= '0;
            out_is_data     <= 1'b0;
            sync_hdr_err    <= 1'b0;
            blk_len_err     <= 1'b0;
        end else begin
            state_q         <= state_d;
            word_cnt_q      <= word_cnt_d;
            lfsr_q          <= lfsr_d;
            out_valid       <= in_valid;
            out_block_start <= in_valid & in_block_start;
            sync_hdr_err    <= hdr_err_d;
            blk_len_err     <= len_err_d;
            if (in_valid) begin
                out_data    <= data_d;
                out_is_data <= is_data_d;
                if (in_block_start)
                    out_sync_hdr <= in_sync_hdr;
            end
        end
    end

endmodule

// File: tb/tb_gen3_rx_descrambler.sv
// Purpose: directed self-checking bench for gen3_rx_descrambler with an independent LFSR model.
// Latency: each driven word is checked 1 pclk after it is sampled.
// Backpressure: none; in_valid gaps are driven explicitly.
module tb_gen3_rx_descrambler;
    import gen3_rx_pkg::*;

    localparam logic [22:0] SEED = 23'h1DBFBC;
    localparam int M_HOLD = 0;
    localparam int M_ADV  = 1;
    localparam int M_EI   = 2;

    logic        pclk;
    logic        reset_n;
    logic [23:0] seed_value;
    logic        lfsr_reset;
    logic        in_valid;
    logic        in_block_start;
    logic [1:0]  in_sync_hdr;
    logic [31:0] in_data;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_block_start;
    logic [1:0]  out_sync_hdr;
    logic        out_is_data;
    logic        sync_hdr_err;
    logic        blk_len_err;

    int          errors;
    int          checks;
    logic [22:0] m;
    logic [22:0] nx;
    logic [31:0] ks;
    logic [31:0] blk [4];
    logic [31:0] p [4];

    gen3_rx_descrambler dut (
        .pclk            (pclk),
        .reset_n         (reset_n),
        .seed_value      (seed_value),
        .lfsr_reset      (lfsr_reset),
        .in_valid        (in_valid),
        .in_block_start  (in_block_start),
        .in_sync_hdr     (in_sync_hdr),
        .in_data         (in_data),
        .out_valid       (out_valid),
        .out_data        (out_data),
        .out_block_start (out_block_start),
        .out_sync_hdr    (out_sync_hdr),
        .out_is_data     (out_is_data),
        .sync_hdr_err    (sync_hdr_err),
        .blk_len_err     (blk_len_err)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Bit-serial golden scrambler: output MSB, rotate left, XOR feedback into taps.
    function automatic void mstep(input logic [22:0] s_in, output logic [31:0] ks_o,
                                  output logic [22:0] s_out);
        logic [22:0] s;
        logic        fb;
        s    = s_in;
        ks_o = '0;
        for (int i = 0; i < 32; i++) begin
            fb      = s[22];
            ks_o[i] = fb;
            s       = {s[21:0], fb};
            s[2]    = s[2]  ^ fb;
            s[5]    = s[5]  ^ fb;
            s[8]    = s[8]  ^ fb;
            s[16]   = s[16] ^ fb;
            s[21]   = s[21] ^ fb;
        end
        s_out = s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one word, let the DUT sample it, then look 1 ns after that edge.
    task automatic drive(input logic v, input logic bs, input logic [1:0] h,
                         input logic [31:0] d, input logic lr);
        in_valid       = v;
        in_block_start = bs;
        in_sync_hdr    = h;
        in_data        = d;
        lfsr_reset     = lr;
        @(posedge pclk);
        #1;
        in_valid       = 1'b0;
        in_block_start = 1'b0;
        lfsr_reset     = 1'b0;
    endtask

    // Four-word data block carrying plaintext base+w*step, scrambled with the model keystream.
    task automatic data_block(input logic [31:0] base, input logic [31:0] step,
                              input logic exp_len);
        logic [31:0] pt;
        for (int w = 0; w < 4; w++) begin
            mstep(m, ks, nx);
            pt = base + 32'(w) * step;
            drive(1'b1, w == 0, SYNC_DATA, pt ^ ks, 1'b0);
            chk("data_valid", {31'd0, out_valid}, 32'd1);
            chk("data_out", out_data, pt);
            chk("data_is_data", {31'd0, out_is_data}, 32'd1);
            chk("data_bstart", {31'd0, out_block_start}, (w == 0) ? 32'd1 : 32'd0);
            chk("data_len_err", {31'd0, blk_len_err}, (w == 0) ? {31'd0, exp_len} : 32'd0);
            m = nx;
        end
        chk("data_hdr", {30'd0, out_sync_hdr}, {30'd0, SYNC_DATA});
    endtask

    // Raw (ordered-set or bad-header) block from blk[]; the model follows the LFSR rule.
    task automatic raw_block(input logic [1:0] h, input int nw, input int mode,
                             input logic exp_len);
        logic hbad;
        hbad = (h == 2'b00) || (h == 2'b11);
        for (int w = 0; w < nw; w++) begin
            drive(1'b1, w == 0, h, blk[w], 1'b0);
            chk("raw_out", out_data, blk[w]);
            chk("raw_is_data", {31'd0, out_is_data}, 32'd0);
            chk("raw_hdr_err", {31'd0, sync_hdr_err}, (w == 0 && hbad) ? 32'd1 : 32'd0);
            chk("raw_len_err", {31'd0, blk_len_err}, (w == 0) ? {31'd0, exp_len} : 32'd0);
            chk("raw_sync_hdr", {30'd0, out_sync_hdr}, {30'd0, h});
            if (mode == M_ADV || (mode == M_EI && w < 3)) begin
                mstep(m, ks, nx);
                m = nx;
            end else if (mode == M_EI) begin
                m = SEED;
            end
        end
    endtask

    initial begin
        errors         = 0;
        checks         = 0;
        reset_n        = 1'b0;
        seed_value     = {1'b0, SEED};
        lfsr_reset     = 1'b0;
        in_valid       = 1'b1;
        in_block_start = 1'b1;
        in_sync_hdr    = SYNC_DATA;
        in_data        = 32'hFFFFFFFF;

        // Reset state with busy inputs.
        repeat (2) @(posedge pclk);
        #1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_is_data", {31'd0, out_is_data}, 32'd0);
        chk("rst_hdr", {30'd0, out_sync_hdr}, 32'd0);
        chk("rst_errs", {30'd0, sync_hdr_err, blk_len_err}, 32'd0);
        reset_n = 1'b1;
        drive(1'b0, 1'b0, 2'b00, 32'd0, 1'b0);
        chk("idle_valid", {31'd0, out_valid}, 32'd0);

        // Keystream fed straight in descrambles to zero.
        m = SEED;
        data_block(32'd0, 32'd0, 1'b0);

        // Generic ordered set advances the LFSR by 128 bits.
        blk = '{32'h1234561E, 32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF};
        raw_block(SYNC_OS, 4, M_ADV, 1'b0);
        data_block(32'hA5A5A5A5, 32'h01010101, 1'b0);

        // Legal 4-word SKP holds the LFSR.
        blk = '{32'hAAAAAAAA, 32'hAAAAAAAA, {24'h3C2D1E, SKP_END_SYM}, 32'h00112233};
        raw_block(SYNC_OS, 4, M_HOLD, 1'b0);
        data_block(32'h13572468, 32'h11111111, 1'b0);

        // 1-word SKP is flagged when the next block starts.
        blk = '{32'hAAAAAAAA, 32'h0, 32'h0, 32'h0};
        raw_block(SYNC_OS, 1, M_HOLD, 1'b0);
        data_block(32'h0F0F0F0F, 32'h00000100, 1'b1);

        // EIEOS re-seeds: the next data block uses the seed keystream.
        blk = '{32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00};
        raw_block(SYNC_OS, 4, M_EI, 1'b0);
        data_block(32'hCAFEBABE, 32'h00000001, 1'b0);

        // Bad header: error pulse on word 0, raw pass, LFSR still advances.
        blk = '{32'h0BADF00D, 32'h11223344, 32'h55667788, 32'h99AABBCC};
        raw_block(2'b11, 4, M_ADV, 1'b0);
        data_block(32'h600DF00D, 32'h00010001, 1'b0);

        // Data block with in_valid gaps and an LFSR re-seed on word 2.
        p = '{32'hC0FFEE00, 32'hC0FFEE11, 32'hC0FFEE22, 32'hC0FFEE33};
        mstep(m, ks, nx);
        drive(1'b1, 1'b1, SYNC_DATA, p[0] ^ ks, 1'b0);
        chk("gap_w0", out_data, p[0]);
        m = nx;
        drive(1'b0, 1'b0, SYNC_DATA, 32'h12345678, 1'b0);
        chk("gap_valid", {31'd0, out_valid}, 32'd0);
        chk("gap_hold", out_data, p[0]);
        mstep(m, ks, nx);
        drive(1'b1, 1'b0, SYNC_DATA, p[1] ^ ks, 1'b0);
        chk("gap_w1", out_data, p[1]);
        m = nx;
        drive(1'b0, 1'b0, SYNC_DATA, 32'h0, 1'b0);
        drive(1'b0, 1'b0, SYNC_DATA, 32'h0, 1'b0);
        chk("gap2_valid", {31'd0, out_valid}, 32'd0);
        mstep(m, ks, nx);
        drive(1'b1, 1'b0, SYNC_DATA, p[2] ^ ks, 1'b1);
        chk("lfsr_rst_w2", out_data, p[2]);
        m = SEED;
        mstep(m, ks, nx);
        drive(1'b1, 1'b0, SYNC_DATA, p[3] ^ ks, 1'b0);
        chk("seed_ks_w3", out_data, p[3]);
        m = nx;

        // Fifth word of a data block: raw, error, no advance; next start flags length too.
        drive(1'b1, 1'b0, SYNC_DATA, 32'h5A5A5A5A, 1'b0);
        chk("overrun_data", out_data, 32'h5A5A5A5A);
        chk("overrun_err", {31'd0, blk_len_err}, 32'd1);
        data_block(32'h87654321, 32'h10000000, 1'b1);

        // Reset mid-block clears outputs and forces a fresh block start.
        mstep(m, ks, nx);
        drive(1'b1, 1'b1, SYNC_DATA, ks, 1'b0);
        chk("pre_rst", out_data, 32'd0);
        reset_n = 1'b0;
        drive(1'b1, 1'b0, SYNC_DATA, 32'hDEADDEAD, 1'b0);
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_data", out_data, 32'd0);
        chk("mid_rst_is_data", {31'd0, out_is_data}, 32'd0);
        chk("mid_rst_hdr", {30'd0, out_sync_hdr}, 32'd0);
        reset_n = 1'b1;
        m = SEED;
        drive(1'b1, 1'b0, SYNC_DATA, 32'h77777777, 1'b0);
        chk("idle_raw", out_data, 32'h77777777);
        chk("idle_is_data", {31'd0, out_is_data}, 32'd0);
        chk("idle_len_err", {31'd0, blk_len_err}, 32'd0);
        data_block(32'h24681357, 32'h02020202, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
